// File: rtl/rvfi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_seq_pkg
// Purpose  : Shared RVFI record type, lane limits and lane-mask helper for the
//            retirement sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rvfi_seq_pkg;

    localparam int RVFI_SEQ_MAX_NRET = 4;
    localparam int RVFI_SEQ_CNT_W    = $clog2(RVFI_SEQ_MAX_NRET + 1);

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic        trap;
        logic        intr;
        logic        halt;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_entry_t;

    function automatic logic [RVFI_SEQ_CNT_W-1:0] lane_popcount(
        input logic [RVFI_SEQ_MAX_NRET-1:0] mask
    );
        logic [RVFI_SEQ_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < RVFI_SEQ_MAX_NRET; i++) begin
            cnt = cnt + {{(RVFI_SEQ_CNT_W-1){1'b0}}, mask[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_seq_fifo
// Purpose  : NRET-write / 1-read circular buffer; occupancy and handshake
//            flags are registered from the next-state pointers.
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_seq_fifo
    import rvfi_seq_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [RVFI_SEQ_CNT_W-1:0]          wr_cnt,
    input  logic [NRET-1:0][W-1:0]             wr_data,
    input  logic                               rd_en,
    output logic [W-1:0]                       rd_data,
    output logic                               out_valid,
    output logic                               in_ready,
    output logic [$clog2(DEPTH+1)-1:0]         count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;

    logic [W-1:0]      r_mem [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_PW-1:0]   w_wr_ptr_nxt;
    logic [c_PW-1:0]   w_rd_ptr_nxt;
    logic [c_PW-1:0]   w_count_nxt;
    logic              r_out_valid;
    logic              r_in_ready;
    logic [c_PW-1:0]   r_count;

    // The wrap bit makes the pointer difference range 0..DEPTH, so full and
    // empty stay distinct without a separate occupancy counter.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (wr_en) begin
            w_wr_ptr_nxt = r_wr_ptr + c_PW'(wr_cnt);
        end
        if (rd_en) begin
            w_rd_ptr_nxt = r_rd_ptr + c_PW'(1);
        end
        w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            r_in_ready  <= (w_count_nxt <= c_PW'(DEPTH - NRET));
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < NRET; j++) begin
            if (wr_en && (RVFI_SEQ_CNT_W'(j) < wr_cnt)) begin
                r_mem[r_wr_ptr[c_AW-1:0] + c_AW'(j)] <= wr_data[j];
            end
        end
    end

    assign rd_data   = r_mem[r_rd_ptr[c_AW-1:0]];
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/rvfi_retire_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_retire_sequencer
// Purpose  : Compacts up to NRET RVFI retirements per cycle into an ordered
//            queue tagged with irq/debug state, feeding the ISS stepper.
//            Optional order checker enabled by RVFI_SEQ_ORDER_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_retire_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NRET-1:0]               in_valid_i,
    input  rvfi_entry_t [NRET-1:0]        in_entry_i,
    output logic                          in_ready_o,
    input  logic [XLEN-1:0]               irq_i,
    input  logic                          debug_req_i,
    output logic                          out_valid_o,
    output rvfi_entry_t                   out_entry_o,
    output logic [XLEN-1:0]               out_irq_o,
    output logic                          out_debug_o,
    input  logic                          out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          overflow_o,
    output logic                          order_err_o
);

    typedef struct packed {
        logic            debug;
        logic [XLEN-1:0] irq;
        rvfi_entry_t     entry;
    } slot_t;

    localparam int c_SW = $bits(slot_t);

    logic [RVFI_SEQ_MAX_NRET-1:0] w_valid_ext;
    logic [RVFI_SEQ_CNT_W-1:0]    w_push_cnt;
    logic                         w_any_valid;
    logic                         w_push;
    logic                         w_pop;
    slot_t [NRET-1:0]             w_comp;
    logic [c_SW-1:0]              w_head_bits;
    slot_t                        w_head;
    logic                         r_overflow;

    assign w_valid_ext = RVFI_SEQ_MAX_NRET'(in_valid_i);
    assign w_push_cnt  = lane_popcount(w_valid_ext);
    assign w_any_valid = |in_valid_i;
    assign w_push      = w_any_valid && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    // Slot j takes the valid lane that has exactly j valid lanes below it.
    always_comb begin
        w_comp = '0;
        for (int j = 0; j < NRET; j++) begin
            for (int i = 0; i < NRET; i++) begin
                if (in_valid_i[i] &&
                    (lane_popcount(w_valid_ext &
                        ((RVFI_SEQ_MAX_NRET'(1) << i) - RVFI_SEQ_MAX_NRET'(1)))
                        == RVFI_SEQ_CNT_W'(j))) begin
                    w_comp[j].debug = debug_req_i;
                    w_comp[j].irq   = irq_i;
                    w_comp[j].entry = in_entry_i[i];
                end
            end
        end
    end

    rvfi_seq_fifo #(
        .NRET  (NRET),
        .DEPTH (DEPTH),
        .W     (c_SW)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .wr_en     (w_push),
        .wr_cnt    (w_push_cnt),
        .wr_data   (w_comp),
        .rd_en     (w_pop),
        .rd_data   (w_head_bits),
        .out_valid (out_valid_o),
        .in_ready  (in_ready_o),
        .count     (count_o)
    );

    // Unused buffer slots hold stale data; the head is forced to zero when empty.
    assign w_head      = slot_t'(w_head_bits);
    assign out_entry_o = out_valid_o ? w_head.entry : '0;
    assign out_irq_o   = out_valid_o ? w_head.irq   : '0;
    assign out_debug_o = out_valid_o ? w_head.debug : 1'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_any_valid && !in_ready_o) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_o = r_overflow;

`ifdef RVFI_SEQ_ORDER_CHECK_EN
    logic        r_exp_loaded;
    logic [63:0] r_exp_order;
    logic        r_order_err;
    logic        w_loaded_nxt;
    logic [63:0] w_exp_nxt;
    logic        w_err_nxt;

    // A mismatch resyncs to the observed order, so each accepted entry simply
    // sets the next expectation to its own order + 1.
    always_comb begin
        w_loaded_nxt = r_exp_loaded;
        w_exp_nxt    = r_exp_order;
        w_err_nxt    = r_order_err;
        if (w_push) begin
            for (int i = 0; i < NRET; i++) begin
                if (in_valid_i[i]) begin
                    if (w_loaded_nxt && (in_entry_i[i].order != w_exp_nxt)) begin
                        w_err_nxt = 1'b1;
                    end
                    w_loaded_nxt = 1'b1;
                    w_exp_nxt    = in_entry_i[i].order + 64'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_exp_loaded <= 1'b0;
            r_exp_order  <= '0;
            r_order_err  <= 1'b0;
        end else begin
            r_exp_loaded <= w_loaded_nxt;
            r_exp_order  <= w_exp_nxt;
            r_order_err  <= w_err_nxt;
        end
    end

    assign order_err_o = r_order_err;
`else
    assign order_err_o = 1'b0;
`endif

endmodule
`default_nettype wire
